seq_pattern_tx: RTL and testbench

- Serial frame transmitter that drives a single-bit line towards the overlapping "101"-marker Moore sequence detector.
- Accepts a parallel data word over a valid/ready handshake and emits a frame: the marker preamble 1,0,1, then the payload LSB-first, then an inter-frame gap of zeros.
- Sits upstream of the detector in the serial test path and gives the detector bench a deterministic, cycle-exact stimulus source.

---
 rtl/seq_pattern_tx.sv | 163 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload LSB-first, then a zero gap.
// Build option SEQ_TX_PARITY_EN inserts one even-parity bit after the payload.
module seq_pattern_tx #(
   parameter  int DATA_W     = 8,
   parameter  int GAP_CYCLES = 2,
   localparam int LEN_W      = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic [LEN_W-1:0]  load_len,
   output logic              tx_out,
   output logic              tx_active,
   output logic              frame_done
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
`ifdef SEQ_TX_PARITY_EN
      PAR,
`endif
      GAP
   } state_t;

   state_t              state, state_nxt;
   logic [1:0]          pre_idx, pre_nxt;
   logic [DATA_W-1:0]   shreg, shreg_nxt;
   logic [LEN_W-1:0]    bit_cnt, cnt_nxt;
   logic [GAP_W-1:0]    gap_cnt, gap_nxt;
   logic                tx_nxt, active_nxt, done_nxt;
`ifdef SEQ_TX_PARITY_EN
   logic                parity, par_nxt;
`endif

   // Zero or out-of-range lengths fall back to a full-width payload.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      if (len == '0 || len > LEN_W'(DATA_W))
         return LEN_W'(DATA_W);
      return len;
   endfunction

   assign load_ready = (state == IDLE);

   always_comb begin
      state_nxt = state;
      pre_nxt   = pre_idx;
      shreg_nxt = shreg;
      cnt_nxt   = bit_cnt;
      gap_nxt   = gap_cnt;
`ifdef SEQ_TX_PARITY_EN
      par_nxt   = parity;
`endif
      unique case (state)
         IDLE: begin
            if (load_valid) begin
               state_nxt = PRE;
               pre_nxt   = 2'd0;
               shreg_nxt = load_data;
               cnt_nxt   = eff_len(load_len);
`ifdef SEQ_TX_PARITY_EN
               par_nxt   = 1'b0;
`endif
            end
         end
         PRE: begin
            if (pre_idx == 2'd2)
               state_nxt = DATA;
            else
               pre_nxt = pre_idx + 2'd1;
         end
         DATA: begin
            // bit_cnt counts the bits still to send, including the one on the line now.
            shreg_nxt = shreg >> 1;
            cnt_nxt   = bit_cnt - LEN_W'(1);
`ifdef SEQ_TX_PARITY_EN
            par_nxt   = parity ^ shreg[0];
`endif
            if (bit_cnt == LEN_W'(1)) begin
`ifdef SEQ_TX_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = GAP;
`endif
               gap_nxt = '0;
            end
         end
`ifdef SEQ_TX_PARITY_EN
         PAR: begin
            state_nxt = GAP;
            gap_nxt   = '0;
         end
`endif
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_nxt = IDLE;
            else
               gap_nxt = gap_cnt + GAP_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so the line matches the state.
   always_comb begin
      tx_nxt     = 1'b0;
      active_nxt = 1'b0;
      done_nxt   = 1'b0;
      unique case (state_nxt)
         PRE: begin
            tx_nxt     = (pre_nxt != 2'd1);
            active_nxt = 1'b1;
         end
         DATA: begin
            tx_nxt     = shreg_nxt[0];
            active_nxt = 1'b1;
         end
`ifdef SEQ_TX_PARITY_EN
         PAR: begin
            tx_nxt     = par_nxt;
            active_nxt = 1'b1;
         end
`endif
         GAP:     done_nxt = (gap_nxt == GAP_LAST);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pre_idx    <= 2'd0;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         tx_out     <= 1'b0;
         tx_active  <= 1'b0;
         frame_done <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         pre_idx    <= pre_nxt;
         shreg      <= shreg_nxt;
         bit_cnt    <= cnt_nxt;
         gap_cnt    <= gap_nxt;
         tx_out     <= tx_nxt;
         tx_active  <= active_nxt;
         frame_done <= done_nxt;
`ifdef SEQ_TX_PARITY_EN
         parity     <= par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table of frames checked cycle by cycle through an expected-output queue.
module tb_seq_pattern_tx;

   localparam int DATA_W     = 8;
   localparam int GAP_CYCLES = 2;
   localparam int LEN_W      = $clog2(DATA_W) + 1;

   logic              clk;
   logic              reset;
   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;
   logic [LEN_W-1:0]  load_len;
   logic              tx_out;
   logic              tx_active;
   logic              frame_done;

   seq_pattern_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .load_len  (load_len),
      .tx_out    (tx_out),
      .tx_active (tx_active),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic tx;
      logic act;
      logic done;
   } exp_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [LEN_W-1:0]  len;
      int                exp_len;
      logic              exp_par;
      bit                poke;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push_frame(input logic [DATA_W-1:0] d, input int n, input logic par);
      sb.push_back('{1'b1, 1'b1, 1'b0});
      sb.push_back('{1'b0, 1'b1, 1'b0});
      sb.push_back('{1'b1, 1'b1, 1'b0});
      for (int i = 0; i < n; i++) sb.push_back('{d[i], 1'b1, 1'b0});
`ifdef SEQ_TX_PARITY_EN
      sb.push_back('{par, 1'b1, 1'b0});
`else
      if (par === 1'bz) $display("unexpected parity value");
`endif
      for (int g = 0; g < GAP_CYCLES; g++) sb.push_back('{1'b0, 1'b0, (g == GAP_CYCLES - 1)});
   endtask

   task automatic compare_cycle(input string tag, input int cyc);
      exp_t e;
      e = sb.pop_front();
      check($sformatf("%s c%0d tx_out", tag, cyc), 32'(tx_out), 32'(e.tx));
      check($sformatf("%s c%0d tx_active", tag, cyc), 32'(tx_active), 32'(e.act));
      check($sformatf("%s c%0d frame_done", tag, cyc), 32'(frame_done), 32'(e.done));
      check($sformatf("%s c%0d load_ready", tag, cyc), 32'(load_ready), 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (load_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t == 50) check({tag, " ready timeout"}, 32'(load_ready), 32'd1);
   endtask

   task automatic run_frame(input string tag, input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len,
                            input int exp_len, input logic exp_par, input bit poke);
      int cyc;
      wait_ready(tag);
      load_valid = 1'b1;
      load_data  = d;
      load_len   = len;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_data  = DATA_W'($urandom);
      load_len   = LEN_W'($urandom);
      push_frame(d, exp_len, exp_par);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         cyc++;
         compare_cycle(tag, cyc);
         if (poke) begin
            // Request a new all-ones frame while the payload is still on the line.
            load_valid = (cyc >= 4 && cyc < 9);
            load_data  = 8'hFF;
            load_len   = LEN_W'(8);
         end
      end
      load_valid = 1'b0;
      @(negedge clk);
      check({tag, " ready after frame"}, 32'(load_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 4'd8,  8, 1'b0, 1'b1};
      vecs[1] = '{8'h06, 4'd3,  3, 1'b0, 1'b0};
      vecs[2] = '{8'h3C, 4'd0,  8, 1'b0, 1'b0};
      vecs[3] = '{8'h81, 4'd15, 8, 1'b0, 1'b0};
      vecs[4] = '{8'h07, 4'd8,  8, 1'b1, 1'b0};
      vecs[5] = '{8'h03, 4'd8,  8, 1'b0, 1'b0};
      vecs[6] = '{8'hFE, 4'd2,  2, 1'b1, 1'b0};
      vecs[7] = '{8'h80, 4'd8,  8, 1'b1, 1'b0};
      vecs[8] = '{8'hFF, 4'd8,  8, 1'b0, 1'b0};
      vecs[9] = '{8'h01, 4'd1,  1, 1'b1, 1'b0};

      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_len   = '0;
      @(posedge clk);
      @(negedge clk);
      check("ready during reset", 32'(load_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset tx_out", 32'(tx_out), 32'd0);
      check("reset tx_active", 32'(tx_active), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset load_ready", 32'(load_ready), 32'd1);

      for (int v = 0; v < 10; v++)
         run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].len,
                   vecs[v].exp_len, vecs[v].exp_par, vecs[v].poke);

      // Reset lands while payload bit 4 of an all-ones frame is on the line.
      wait_ready("abort");
      load_valid = 1'b1;
      load_data  = 8'hFF;
      load_len   = LEN_W'(8);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      push_frame(8'hFF, 8, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         compare_cycle("abort", c);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("abort idle%0d line", c), {29'd0, tx_out, tx_active, frame_done}, 32'd0);
         check($sformatf("abort idle%0d ready", c), 32'(load_ready), 32'd1);
      end
      run_frame("after abort", 8'h01, LEN_W'(1), 1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
